sum_uart_sequencer: RTL and testbench
=====================================

SUM_UART_SEQUENCER -- requirements
Module: sum_uart_sequencer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on each asynchronous input (save_a_n, save_b_n, uart_tx_en); legal 2..3.
REQ-002 The block SHALL have parameter SEND_CRLF, default 1, where 1 appends CR LF to each message and 0 sends digits only.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 save_a_n  input  1  active-low operand-A capture button, asynchronous.
REQ-006 save_b_n  input  1  active-low operand-B capture button, asynchronous.
REQ-007 data_input  input  4  operand value, unsigned.
REQ-008 uart_tx_en  input  1  transmit request, asynchronous, acted on at rising edge.
REQ-009 uart_busy  input  1  busy flag from the downstream UART transmitter.
REQ-010 tx_data  output  8  byte to the UART, registered.
REQ-011 tx_start  output  1  one-cycle start strobe to the UART, registered.
REQ-012 seq_busy  output  1  high while a message is in flight.
REQ-013 sum_out  output  5  registered A+B.
REQ-014 overrun  output  1  sticky flag: request dropped.

Function
REQ-015 save_a_n, save_b_n and uart_tx_en SHALL each pass through SYNC_STAGES flops before use; events are edges of the synchronized signals.
REQ-016 A synchronized falling edge of save_a_n SHALL load data_input into operand A; likewise save_b_n into operand B; simultaneous edges load both in the same cycle.
REQ-017 sum_out SHALL equal zero-extended A + B, 5 bits, no overflow possible (max 30), updated the cycle after an operand load.
REQ-018 FSM states: IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT.
REQ-019 IDLE: synchronized rising edge of uart_tx_en -> LOAD; seq_busy goes high on entering LOAD.
REQ-020 LOAD: snapshot sum_out into a message register, byte index = 0, -> SEND; later operand loads SHALL NOT alter the in-flight message.
REQ-021 SEND: if uart_busy = 0, drive tx_data with the current byte, pulse tx_start for exactly one cycle, -> WAIT_HI; if uart_busy = 1, hold in SEND with tx_start low.
REQ-022 WAIT_HI: stay until uart_busy = 1, then -> WAIT_LO; tx_data held stable.
REQ-023 WAIT_LO: stay until uart_busy = 0, then -> NEXT.
REQ-024 NEXT: increment index; if more bytes -> SEND, else -> IDLE with seq_busy low on entering IDLE.
REQ-025 Message byte 0 SHALL be ASCII of sum bit 4 (0x30 or 0x31); byte 1 ASCII hex of sum[3:0] (0..9 -> 0x30+n, A..F -> 0x41+n-10, uppercase); bytes 2,3 = 0x0D, 0x0A when SEND_CRLF = 1.
REQ-026 Message length SHALL be 4 bytes when SEND_CRLF = 1, otherwise 2.
REQ-027 First tx_start SHALL occur SYNC_STAGES+3 cycles after the first clk edge sampling uart_tx_en high, given uart_busy low.
REQ-028 A synchronized uart_tx_en rising edge while state != IDLE SHALL be ignored and SHALL set overrun = 1; overrun clears only on reset.
REQ-029 tx_start SHALL never be asserted while uart_busy = 1 in the same cycle, nor in any state other than SEND.

Reset
REQ-030 reset high SHALL immediately force IDLE, tx_start = 0, tx_data = 0x00, seq_busy = 0, sum_out = 0, operands A = B = 0, overrun = 0, synchronizers to the inactive level (save_*_n = 1, uart_tx_en = 0).
REQ-031 Reset asserted mid-message SHALL abandon the message; after release no byte resumes until a new uart_tx_en rising edge.

Verification
REQ-032 Assert reset -> all outputs 0 asynchronously, before next clk edge.
REQ-033 data 4'h9 + save_a_n pulse, data 4'h7 + save_b_n pulse, uart_tx_en edge, UART model busy 10 cycles per byte -> sum_out = 0x10; bytes 0x31, 0x30, 0x0D, 0x0A, each tx_start exactly one cycle.
REQ-034 A = B = 4'hF, SEND_CRLF = 0 -> sum_out = 30; bytes 0x31, 0x45 only; seq_busy low after second byte completes.
REQ-035 Second uart_tx_en edge during byte 1 -> overrun = 1, message unchanged, no second message; save_a_n pulse with data 4'h0 mid-message -> sum_out updates, remaining bytes unchanged.
REQ-036 Hold uart_busy = 1 before first byte -> tx_start stays low, fires one cycle window after busy drops.
REQ-037 Reset pulse while in WAIT_LO -> tx_start and seq_busy low immediately, no further bytes after release.

Source files
------------

// File: rtl/sum_uart_sequencer.sv
// Purpose : captures two 4-bit operands from asynchronous buttons, keeps their
//           registered sum, and on a transmit request sends the sum to a UART as
//           ASCII ("0"/"1", hex digit, optional CR LF), one byte per busy handshake.
// Ports   : clk, reset (async, active-high); save_a_n/save_b_n/uart_tx_en (async
//           inputs, synchronized); data_input (operand); uart_busy (from UART);
//           tx_data/tx_start (byte + one-cycle strobe to UART); seq_busy, sum_out,
//           overrun (sticky: request arrived while a message was in flight).
module sum_uart_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter bit SEND_CRLF   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       save_a_n,
  input  logic       save_b_n,
  input  logic [3:0] data_input,
  input  logic       uart_tx_en,
  input  logic       uart_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       seq_busy,
  output logic [4:0] sum_out,
  output logic       overrun
);

  localparam int         MSG_LEN  = SEND_CRLF ? 4 : 2;
  localparam logic [1:0] LAST_IDX = 2'(MSG_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, NEXT} state_t;

  logic [SYNC_STAGES-1:0] sync_a, sync_b, sync_en;
  logic                   prev_a, prev_b, prev_en;
  logic                   en_rise_q;
  logic                   fall_a, fall_b, en_rise;
  logic [3:0]             op_a, op_b;
  state_t                 state;
  logic [4:0]             msg_sum;
  logic [1:0]             idx;

  // Edges are taken between the last synchronizer flop and one extra history flop.
  assign fall_a  = prev_a & ~sync_a[SYNC_STAGES-1];
  assign fall_b  = prev_b & ~sync_b[SYNC_STAGES-1];
  assign en_rise = ~prev_en & sync_en[SYNC_STAGES-1];

  // Synchronizers reset to the inactive level so reset release creates no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a    <= '1;
      sync_b    <= '1;
      sync_en   <= '0;
      prev_a    <= 1'b1;
      prev_b    <= 1'b1;
      prev_en   <= 1'b0;
      en_rise_q <= 1'b0;
    end else begin
      sync_a    <= {sync_a[SYNC_STAGES-2:0], save_a_n};
      sync_b    <= {sync_b[SYNC_STAGES-2:0], save_b_n};
      sync_en   <= {sync_en[SYNC_STAGES-2:0], uart_tx_en};
      prev_a    <= sync_a[SYNC_STAGES-1];
      prev_b    <= sync_b[SYNC_STAGES-1];
      prev_en   <= sync_en[SYNC_STAGES-1];
      en_rise_q <= en_rise;
    end
  end

  // Operands and their sum; sum_out trails an operand load by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a    <= 4'h0;
      op_b    <= 4'h0;
      sum_out <= 5'h00;
    end else begin
      if (fall_a) op_a <= data_input;
      if (fall_b) op_b <= data_input;
      sum_out <= {1'b0, op_a} + {1'b0, op_b};
    end
  end

  // Byte i of the message for sum s: bit 4 as '0'/'1', low nibble as uppercase hex, CR, LF.
  function automatic logic [7:0] msg_byte(input logic [4:0] s, input logic [1:0] i);
    logic [7:0] nib;
    nib = {4'h0, s[3:0]};
    case (i)
      2'd0:    msg_byte = {7'b0011000, s[4]};
      2'd1:    msg_byte = (s[3:0] < 4'd10) ? (8'h30 + nib) : (8'h37 + nib);
      2'd2:    msg_byte = 8'h0D;
      default: msg_byte = 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      seq_busy <= 1'b0;
      msg_sum  <= 5'h00;
      idx      <= 2'd0;
      overrun  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (en_rise_q && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (en_rise_q) begin
            state    <= LOAD;
            seq_busy <= 1'b1;
          end
        end
        LOAD: begin
          // Snapshot so operand loads during transmission cannot change the message.
          msg_sum <= sum_out;
          idx     <= 2'd0;
          state   <= SEND;
        end
        SEND: begin
          if (!uart_busy) begin
            tx_data  <= msg_byte(msg_sum, idx);
            tx_start <= 1'b1;
            state    <= WAIT_HI;
          end
        end
        WAIT_HI: if (uart_busy)  state <= WAIT_LO;
        WAIT_LO: if (!uart_busy) state <= NEXT;
        NEXT: begin
          if (idx == LAST_IDX) begin
            state    <= IDLE;
            seq_busy <= 1'b0;
          end else begin
            idx   <= idx + 2'd1;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_uart_sequencer.sv
// Bench for sum_uart_sequencer: two instances (with and without CR LF) share the
// operand/request stimulus; each has its own UART busy model and byte scoreboard.
module tb_sum_uart_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sa = 1'b1, sb = 1'b1, en = 1'b0;
  logic [3:0] data = 4'h0;
  logic       force_busy = 1'b0;

  logic [7:0] tx_data1, tx_data0;
  logic       tx_start1, tx_start0, seq_busy1, seq_busy0, ovr1, ovr0, busy1, busy0;
  logic [4:0] sum1, sum0;

  int checks = 0;
  int failures = 0;

  // Model state: operand values, expected byte streams, captured byte logs.
  int         exp_a = 0, exp_b = 0;
  bit         sum_stable = 1'b0;
  logic [7:0] q1[$], q0[$], log1[$], log0[$];
  logic       prev_start1 = 1'b0, prev_start0 = 1'b0;
  int         cnt1 = 0, cnt0 = 0;

  always #5 clk = ~clk;

  sum_uart_sequencer #(.SYNC_STAGES(SYNC), .SEND_CRLF(1'b1)) dut1 (
    .clk(clk), .reset(reset), .save_a_n(sa), .save_b_n(sb), .data_input(data),
    .uart_tx_en(en), .uart_busy(busy1), .tx_data(tx_data1), .tx_start(tx_start1),
    .seq_busy(seq_busy1), .sum_out(sum1), .overrun(ovr1));

  sum_uart_sequencer #(.SYNC_STAGES(SYNC), .SEND_CRLF(1'b0)) dut0 (
    .clk(clk), .reset(reset), .save_a_n(sa), .save_b_n(sb), .data_input(data),
    .uart_tx_en(en), .uart_busy(busy0), .tx_data(tx_data0), .tx_start(tx_start0),
    .seq_busy(seq_busy0), .sum_out(sum0), .overrun(ovr0));

  // UART model: busy for 10 cycles after each accepted start strobe.
  always @(posedge clk) begin
    if (tx_start1) cnt1 <= 10; else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    if (tx_start0) cnt0 <= 10; else if (cnt0 != 0) cnt0 <= cnt0 - 1;
  end
  assign busy1 = force_busy | (cnt1 != 0);
  assign busy0 = force_busy | (cnt0 != 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Expected message for a sum, derived from the ASCII rules with plain arithmetic.
  task automatic push_msg(input int s);
    int lo;
    logic [7:0] b0, b1;
    lo = s % 16;
    b0 = 8'(48 + s / 16);
    b1 = (lo < 10) ? 8'(48 + lo) : 8'(65 + lo - 10);
    q1.push_back(b0); q1.push_back(b1); q1.push_back(8'h0D); q1.push_back(8'h0A);
    q0.push_back(b0); q0.push_back(b1);
  endtask

  task automatic mon(input int id, input logic st, input logic [7:0] d, input logic b,
                     input logic sbz, input logic pst);
    logic [7:0] e;
    if (!st) return;
    chk(id ? "start_while_busy1" : "start_while_busy0", b, 0);
    chk(id ? "start_width1" : "start_width0", pst, 0);
    chk(id ? "start_seq_busy1" : "start_seq_busy0", sbz, 1);
    if ((id ? q1.size() : q0.size()) == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_byte%0d actual=%0h required=none", id, d);
    end else begin
      e = id ? q1.pop_front() : q0.pop_front();
      chk(id ? "byte1" : "byte0", d, e);
    end
    if (id) log1.push_back(d); else log0.push_back(d);
  endtask

  // Single compare process: sum against model, every strobe against scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (sum_stable) begin
        chk("sum_out1", sum1, exp_a + exp_b);
        chk("sum_out0", sum0, exp_a + exp_b);
      end
      mon(1, tx_start1, tx_data1, busy1, seq_busy1, prev_start1);
      mon(0, tx_start0, tx_data0, busy0, seq_busy0, prev_start0);
    end
    prev_start1 = tx_start1;
    prev_start0 = tx_start0;
  end

  task automatic press(input int which, input logic [3:0] v);
    @(negedge clk);
    sum_stable = 1'b0;
    data = v;
    if (which & 1) sa = 1'b0;
    if (which & 2) sb = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    sa = 1'b1; sb = 1'b1;
    if (which & 1) exp_a = v;
    if (which & 2) exp_b = v;
    repeat (SYNC + 3) @(negedge clk);
    sum_stable = 1'b1;
  endtask

  // Request a message; optionally measure edges from first sampling edge to tx_start.
  task automatic req(input bit check_lat);
    int n;
    @(negedge clk);
    push_msg(exp_a + exp_b);
    en = 1'b1;
    @(posedge clk);
    if (check_lat) begin
      n = 1;
      while (n <= 20) begin
        @(posedge clk); #1;
        if (tx_start1) break;
        n++;
      end
      chk("first_start_latency", n, SYNC + 3);
    end else begin
      repeat (SYNC + 5) @(posedge clk);
    end
    @(negedge clk);
    chk("seq_busy_on_request", seq_busy1, 1);
    en = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while ((seq_busy1 || seq_busy0) && i < 400);
    chk("idle_reached", {seq_busy1, seq_busy0}, 0);
    chk("q1_drained", q1.size(), 0);
    chk("q0_drained", q0.size(), 0);
  endtask

  initial begin
    int i;
    // Reset state before any clock edge.
    #2;
    chk("rst_tx_data", tx_data1, 0);
    chk("rst_tx_start", tx_start1, 0);
    chk("rst_seq_busy", seq_busy1, 0);
    chk("rst_sum_out", sum1, 0);
    chk("rst_overrun", ovr1, 0);
    chk("rst_sum_out0", sum0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sum_stable = 1'b1;

    // 9 + 7 = 0x10 -> "10\r\n"
    press(1, 4'h9);
    press(2, 4'h7);
    chk("sum_9_7", sum1, 5'h10);
    log1.delete(); log0.delete();
    req(1);
    wait_idle();
    chk("log1_len", log1.size(), 4);
    if (log1.size() == 4) begin
      chk("b0_31", log1[0], 8'h31); chk("b1_30", log1[1], 8'h30);
      chk("b2_0d", log1[2], 8'h0D); chk("b3_0a", log1[3], 8'h0A);
    end
    chk("log0_len", log0.size(), 2);

    // Simultaneous capture: A = B = F -> 30 -> "1E" (no CR LF on dut0).
    press(3, 4'hF);
    chk("sum_f_f", sum0, 5'd30);
    log1.delete(); log0.delete();
    req(0);
    wait_idle();
    chk("log0_len_crlf0", log0.size(), 2);
    if (log0.size() == 2) begin
      chk("c0_b0_31", log0[0], 8'h31); chk("c0_b1_45", log0[1], 8'h45);
    end
    chk("seq_busy0_after", seq_busy0, 0);

    // Second request mid-message sets overrun; operand change does not alter message.
    log1.delete(); log0.delete();
    chk("overrun_before", ovr1, 0);
    req(0);
    i = 0;
    while (log1.size() < 2 && i < 200) begin @(negedge clk); i++; end
    en = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    en = 1'b0;
    press(1, 4'h0);
    chk("sum_mid_msg", sum1, 5'd15);
    wait_idle();
    repeat (40) @(negedge clk);
    chk("overrun1", ovr1, 1);
    chk("overrun0", ovr0, 1);
    chk("no_second_msg1", log1.size(), 4);
    if (log1.size() == 4) chk("msg_unchanged_b1", log1[1], 8'h45);

    // Busy held before first byte: no strobe until it drops, then on the next edge.
    log1.delete(); log0.delete();
    force_busy = 1'b1;
    req(0);
    repeat (10) @(negedge clk);
    chk("no_start_while_held", log1.size(), 0);
    force_busy = 1'b0;
    @(posedge clk); #1;
    chk("start_after_release", tx_start1, 1);
    wait_idle();
    if (log1.size() == 4) chk("held_b1_46", log1[1], 8'h46);

    // Reset while waiting for busy to fall abandons the message.
    log1.delete(); log0.delete();
    req(0);
    i = 0;
    while (!busy1 && i < 50) begin @(negedge clk); i++; end
    repeat (2) @(negedge clk);
    #2;
    sum_stable = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_seq_busy", seq_busy1, 0);
    chk("mid_rst_tx_start", tx_start1, 0);
    chk("mid_rst_tx_data", tx_data1, 0);
    chk("mid_rst_sum", sum1, 0);
    chk("mid_rst_overrun", ovr1, 0);
    q1.delete(); q0.delete();
    exp_a = 0; exp_b = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sum_stable = 1'b1;
    repeat (80) @(negedge clk);
    chk("no_resume_bytes", log1.size(), 1);
    chk("no_resume_busy", seq_busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
